// File: rtl/counter_pkg.sv
// Shared constants and types for the modulo-14 up/down counter.
package counter_pkg;

  localparam int unsigned CNT_WIDTH   = 4;
  localparam int unsigned CNT_MODULUS = 14;

  localparam int unsigned NUMBER_OF_TRANSACTIONS = 100;

  typedef logic [CNT_WIDTH-1:0] count_t;

  // Count direction as seen on the mode pin.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // One stimulus/response record for the counter bench environment.
  typedef struct packed {
    logic   rest;
    logic   load;
    logic   mode;
    count_t data_in;
    count_t data_out;
  } transaction_t;

endpackage

// File: rtl/mod14_next_state.sv
// Combinational next-count logic: load range check plus wrapping up/down count.
module mod14_next_state
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH,
  parameter int unsigned MODULUS = CNT_MODULUS
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  dir_e dir;
  assign dir = dir_e'(mode_i);

  // Load wins over counting; out-of-range loads collapse to zero.
  always_comb begin
    next_o = count_i;
    if (load_i) begin
      if (data_in_i <= MAX_VAL) next_o = data_in_i;
      else                      next_o = '0;
    end else if (dir == DIR_UP) begin
      if (count_i >= MAX_VAL) next_o = '0;
      else                    next_o = count_i + WIDTH'(1);
    end else begin
      if (count_i == '0)      next_o = MAX_VAL;
      else                    next_o = count_i - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod14_updown_counter.sv
// Loadable modulo-14 up/down counter with synchronous active-high reset.
module mod14_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH,
  parameter int unsigned MODULUS = CNT_MODULUS
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  mod14_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count_i  (count_q),
    .load_i   (load),
    .mode_i   (mode),
    .data_in_i(data_in),
    .next_o   (count_d)
  );

  // Count register; reset overrides load and count.
  always_ff @(posedge clock) begin
    if (rest) count_q <= '0;
    else      count_q <= count_d;
  end

  assign data_out = count_q;

endmodule

// File: tb/tb_mod14_updown_counter.sv
// Directed-vector and reference-model bench for the modulo-14 counter.
module tb_mod14_updown_counter;
  import counter_pkg::*;

  logic   clock = 1'b0;
  logic   rest;
  logic   load;
  logic   mode;
  count_t data_in;
  count_t data_out;

  int total = 0;
  int bad   = 0;

  mod14_updown_counter #(
    .WIDTH  (CNT_WIDTH),
    .MODULUS(CNT_MODULUS)
  ) dut (
    .clock   (clock),
    .rest    (rest),
    .load    (load),
    .mode    (mode),
    .data_in (data_in),
    .data_out(data_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic   rest;
    logic   load;
    logic   mode;
    count_t din;
    count_t exp;
    string  name;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input count_t exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, data_out, exp);
    end
  endtask

  // Apply one set of inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic r, input logic l, input logic m, input count_t d);
    rest    = r;
    load    = l;
    mode    = m;
    data_in = d;
    @(posedge clock);
    #1;
  endtask

  function automatic int model(input int cur, input logic r, input logic l,
                               input logic m, input int d);
    if (r)      return 0;
    if (l)      return (d < 14) ? d : 0;
    if (m)      return (cur + 1) % 14;
    return (cur + 13) % 14;
  endfunction

  initial begin
    int m_val;
    rest = 1'b1; load = 1'b0; mode = 1'b0; data_in = '0;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd9,  4'd0,  "reset0"};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd9,  4'd0,  "reset1"};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd12, 4'd12, "load12"};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd13, "up13"};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  "upwrap0"};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd1,  "up1"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd1,  4'd1,  "load1"};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  "down0"};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd13, "downwrap13"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd12, "down12"};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd13, 4'd13, "load13"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd14, 4'd0,  "load14"};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd0,  "load15"};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'd5,  4'd5,  "loadup_noinc"};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 4'd7,  4'd0,  "rest_over_load"};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd1,  "up_after_rst"};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd2,  "up2"};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  "rst_midcount"};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rest, vecs[i].load, vecs[i].mode, vecs[i].din);
      check(vecs[i].name, vecs[i].exp);
    end

    // Every load value, each preceded by a count step so the load must change state.
    m_val = 0;
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      m_val = (m_val + 13) % 14;
      check("pre_load_down", count_t'(m_val));
      step(1'b0, 1'b1, v[0], count_t'(v));
      m_val = (v < 14) ? v : 0;
      check($sformatf("loadall_%0d", v), count_t'(m_val));
    end

    // Random regression against the reference model.
    for (int t = 0; t < int'(NUMBER_OF_TRANSACTIONS); t++) begin
      logic   r, l, md;
      count_t d;
      r  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 3) == 0);
      md = 1'($urandom_range(0, 1));
      d  = count_t'($urandom_range(0, 15));
      step(r, l, md, d);
      m_val = model(m_val, r, l, md, int'(d));
      check("random", count_t'(m_val));
      total++;
      if (!(data_out < 4'd14)) begin
        bad++;
        $display("FAIL invariant: got=%0d want=<14", data_out);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
